// File: rtl/vga_timing_pkg.sv
// 640x480@60 timing constants and the per-axis phase type shared by the VGA sync generator.
package vga_timing_pkg;

    localparam int CNT_W   = 10;
    localparam int CNT_MAX = 1 << CNT_W;

    localparam int VGA_CLK_DIV  = 4;
    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;
    localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

    typedef enum logic [1:0] {
        PH_ACTIVE = 2'd0,
        PH_FRONT  = 2'd1,
        PH_SYNC   = 2'd2,
        PH_BACK   = 2'd3
    } phase_e;

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: count 0..TOTAL-1 with a phase tracker.
// phase | meaning: ACTIVE visible, FRONT front porch, SYNC sync pulse, BACK back porch.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int ACTIVE = VGA_H_ACTIVE,
    parameter int FP     = VGA_H_FP,
    parameter int SYNC   = VGA_H_SYNC,
    parameter int BP     = VGA_H_BP
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             wrap_i,
    output logic [CNT_W-1:0] count_o,
    output phase_e           phase_o,
    output logic             wrap_o
);

    localparam int TOTAL = ACTIVE + FP + SYNC + BP;
    localparam logic [CNT_W-1:0] LAST     = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0] FRONT_AT = CNT_W'(ACTIVE);
    localparam logic [CNT_W-1:0] SYNC_AT  = CNT_W'(ACTIVE + FP);
    localparam logic [CNT_W-1:0] BACK_AT  = CNT_W'(ACTIVE + FP + SYNC);

    if (TOTAL > CNT_MAX) begin : g_total_check
        $error("vga_axis_counter: total %0d does not fit in %0d-bit counter", TOTAL, CNT_W);
    end

    logic [CNT_W-1:0] count_q, count_d;
    phase_e           phase_q, phase_d;

    assign wrap_o  = (count_q == LAST);
    assign count_o = count_q;
    assign phase_o = phase_q;

    // Later phases are tested first so a zero-width porch is skipped cleanly.
    always_comb begin
        count_d = count_q;
        phase_d = phase_q;
        if (en_i) begin
            if (wrap_i || (count_q == LAST)) begin
                count_d = '0;
                phase_d = PH_ACTIVE;
            end else begin
                count_d = count_q + 1'b1;
                if (count_d == BACK_AT) begin
                    phase_d = PH_BACK;
                end else if (count_d == SYNC_AT) begin
                    phase_d = PH_SYNC;
                end else if (count_d == FRONT_AT) begin
                    phase_d = PH_FRONT;
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
            phase_q <= PH_ACTIVE;
        end else begin
            count_q <= count_d;
            phase_q <= phase_d;
        end
    end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA timing source: pixel-rate divider, h/v axis counters and registered sync/enable/frame outputs.
// Optional colour-bar test pattern on Red/Green/Blue_Out when VGA_TESTPAT_EN is defined.
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV  = VGA_CLK_DIV,
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic             Master_Clock_In,
    input  logic             Reset_In,
    output logic             Pixel_Tick_Out,
    output logic             HSync_Out,
    output logic             VSync_Out,
    output logic             Disp_Ena_Out,
    output logic [CNT_W-1:0] Val_Col_Out,
    output logic [CNT_W-1:0] Val_Row_Out,
    output logic             Frame_Tick_Out
`ifdef VGA_TESTPAT_EN
    ,
    output logic [3:0]       Red_Out,
    output logic [3:0]       Green_Out,
    output logic [3:0]       Blue_Out
`endif
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_PRE  = DIV_W'(CLK_DIV - 2);
    localparam logic [CNT_W-1:0] V_BLANK_AT = CNT_W'(V_ACTIVE);

    if (CLK_DIV < 2) begin : g_div_check
        $error("vga_sync_gen: CLK_DIV must be at least 2, got %0d", CLK_DIV);
    end

    logic [DIV_W-1:0] div_q, div_d;
    logic             adv;
    logic [CNT_W-1:0] h_cnt, v_cnt;
    phase_e           h_phase, v_phase;
    logic             h_wrap, v_wrap_unused;
    logic             active_now;

    logic             tick_q, tick_d;
    logic             hs_q, hs_d;
    logic             vs_q, vs_d;
    logic             de_q, de_d;
    logic             frame_q, frame_d;
    logic [CNT_W-1:0] col_q, col_d;
    logic [CNT_W-1:0] row_q, row_d;

    // The counters step on the same edge that raises Pixel_Tick, so the
    // registered outputs show the pre-step count for the whole tick period.
    assign adv   = (div_q == DIV_PRE);
    assign div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;

    vga_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP)
    ) u_h_axis (
        .clk_i   (Master_Clock_In),
        .rst_i   (Reset_In),
        .en_i    (adv),
        .wrap_i  (1'b0),
        .count_o (h_cnt),
        .phase_o (h_phase),
        .wrap_o  (h_wrap)
    );

    vga_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP)
    ) u_v_axis (
        .clk_i   (Master_Clock_In),
        .rst_i   (Reset_In),
        .en_i    (adv & h_wrap),
        .wrap_i  (1'b0),
        .count_o (v_cnt),
        .phase_o (v_phase),
        .wrap_o  (v_wrap_unused)
    );

    assign active_now = (h_phase == PH_ACTIVE) && (v_phase == PH_ACTIVE);

    always_comb begin
        tick_d  = adv;
        hs_d    = hs_q;
        vs_d    = vs_q;
        de_d    = de_q;
        col_d   = col_q;
        row_d   = row_q;
        frame_d = 1'b0;
        if (adv) begin
            hs_d    = (h_phase == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
            vs_d    = (v_phase == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
            de_d    = active_now;
            col_d   = h_cnt;
            row_d   = v_cnt;
            frame_d = (h_cnt == '0) && (v_cnt == V_BLANK_AT);
        end
    end

    always_ff @(posedge Master_Clock_In or posedge Reset_In) begin
        if (Reset_In) begin
            div_q   <= '0;
            tick_q  <= 1'b0;
            hs_q    <= ~SYNC_POL;
            vs_q    <= ~SYNC_POL;
            de_q    <= 1'b0;
            col_q   <= '0;
            row_q   <= '0;
            frame_q <= 1'b0;
        end else begin
            div_q   <= div_d;
            tick_q  <= tick_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            de_q    <= de_d;
            col_q   <= col_d;
            row_q   <= row_d;
            frame_q <= frame_d;
        end
    end

    assign Pixel_Tick_Out = tick_q;
    assign HSync_Out      = hs_q;
    assign VSync_Out      = vs_q;
    assign Disp_Ena_Out   = de_q;
    assign Val_Col_Out    = col_q;
    assign Val_Row_Out    = row_q;
    assign Frame_Tick_Out = frame_q;

`ifdef VGA_TESTPAT_EN
    localparam logic [CNT_W-1:0] BAR_W = CNT_W'(H_ACTIVE / 8);

    logic [2:0]  bar;
    logic [11:0] rgb_q, rgb_d;

    // Bar index bits map to {R,G,B}; each set bit drives its channel full scale.
    assign bar = 3'(h_cnt / BAR_W);

    always_comb begin
        rgb_d = rgb_q;
        if (adv) begin
            rgb_d = active_now ? {{4{bar[2]}}, {4{bar[1]}}, {4{bar[0]}}} : 12'h000;
        end
    end

    always_ff @(posedge Master_Clock_In or posedge Reset_In) begin
        if (Reset_In) begin
            rgb_q <= 12'h000;
        end else begin
            rgb_q <= rgb_d;
        end
    end

    assign Red_Out   = rgb_q[11:8];
    assign Green_Out = rgb_q[7:4];
    assign Blue_Out  = rgb_q[3:0];
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Self-checking bench for vga_sync_gen: default timing, CLK_DIV=2/SYNC_POL=1, and a small-geometry full-frame instance.
`timescale 1ns/1ps
module tb_vga_sync_gen;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [9:0] col;
        logic [9:0] row;
        logic       de;
        logic       hs;
        logic       vs;
        logic       ft;
    } rec_t;

    typedef struct {
        int         col;
        logic       de;
        logic       hs;
        logic [11:0] rgb;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: wait budget expired at t=%0t", name, $time);
    endtask

    function automatic rec_t expect_at(input int col, input int row, input int ha, input int hf,
                                       input int hs, input int va, input int vf, input int vs,
                                       input bit pol);
        rec_t r;
        r.col = col[9:0];
        r.row = row[9:0];
        r.de  = (col < ha) && (row < va);
        r.hs  = (col >= ha + hf && col < ha + hf + hs) ? pol : ~pol;
        r.vs  = (row >= va + vf && row < va + vf + vs) ? pol : ~pol;
        r.ft  = (col == 0) && (row == va);
        return r;
    endfunction

    function automatic logic [11:0] rgb_exp(input int col, input logic de);
        int idx;
        idx = col / 80;
        if (!de) return 12'h000;
        return {idx[2] ? 4'hF : 4'h0, idx[1] ? 4'hF : 4'h0, idx[0] ? 4'hF : 4'h0};
    endfunction

    // ---------------- DUT 0: default 640x480, CLK_DIV=4
    logic t0, hs0, vs0, de0, ft0;
    logic [9:0] col0, row0;
`ifdef VGA_TESTPAT_EN
    logic [3:0] r0, g0, b0;
`endif
    vga_sync_gen u_dut0 (
        .Master_Clock_In (clk),
        .Reset_In        (rst),
        .Pixel_Tick_Out  (t0),
        .HSync_Out       (hs0),
        .VSync_Out       (vs0),
        .Disp_Ena_Out    (de0),
        .Val_Col_Out     (col0),
        .Val_Row_Out     (row0),
        .Frame_Tick_Out  (ft0)
`ifdef VGA_TESTPAT_EN
        ,
        .Red_Out         (r0),
        .Green_Out       (g0),
        .Blue_Out        (b0)
`endif
    );

    // ---------------- DUT 1: CLK_DIV=2, SYNC_POL=1
    logic t1, hs1, vs1, de1_unused, ft1_unused;
    logic [9:0] col1, row1;
`ifdef VGA_TESTPAT_EN
    logic [3:0] r1_unused, g1_unused, b1_unused;
`endif
    vga_sync_gen #(.CLK_DIV(2), .SYNC_POL(1'b1)) u_dut1 (
        .Master_Clock_In (clk),
        .Reset_In        (rst),
        .Pixel_Tick_Out  (t1),
        .HSync_Out       (hs1),
        .VSync_Out       (vs1),
        .Disp_Ena_Out    (de1_unused),
        .Val_Col_Out     (col1),
        .Val_Row_Out     (row1),
        .Frame_Tick_Out  (ft1_unused)
`ifdef VGA_TESTPAT_EN
        ,
        .Red_Out         (r1_unused),
        .Green_Out       (g1_unused),
        .Blue_Out        (b1_unused)
`endif
    );

    // ---------------- DUT 2: small geometry 24x19, CLK_DIV=2
    logic t2, hs2, vs2, de2, ft2;
    logic [9:0] col2, row2;
`ifdef VGA_TESTPAT_EN
    logic [3:0] r2_unused, g2_unused, b2_unused;
`endif
    vga_sync_gen #(
        .CLK_DIV(2), .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
        .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(3)
    ) u_dut2 (
        .Master_Clock_In (clk),
        .Reset_In        (rst),
        .Pixel_Tick_Out  (t2),
        .HSync_Out       (hs2),
        .VSync_Out       (vs2),
        .Disp_Ena_Out    (de2),
        .Val_Col_Out     (col2),
        .Val_Row_Out     (row2),
        .Frame_Tick_Out  (ft2)
`ifdef VGA_TESTPAT_EN
        ,
        .Red_Out         (r2_unused),
        .Green_Out       (g2_unused),
        .Blue_Out        (b2_unused)
`endif
    );

    // ---------------- scoreboard models: push expected record when a tick is due
    int   m0_div, m0_col, m0_row;
    bit   m0_tick;
    rec_t q0[$];
    rec_t e0;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m0_div = 0; m0_col = 0; m0_row = 0; m0_tick = 0;
            q0.delete();
        end else begin
            m0_tick = (m0_div == 2);
            if (m0_tick) begin
                q0.push_back(expect_at(m0_col, m0_row, 640, 16, 96, 480, 10, 2, 1'b0));
                if (m0_col == 799) begin
                    m0_col = 0;
                    m0_row = (m0_row == 524) ? 0 : m0_row + 1;
                end else begin
                    m0_col++;
                end
            end
            m0_div = (m0_div == 3) ? 0 : m0_div + 1;
        end
    end

    int   m2_div, m2_col, m2_row;
    bit   m2_tick;
    rec_t q2[$];
    rec_t e2;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m2_div = 0; m2_col = 0; m2_row = 0; m2_tick = 0;
            q2.delete();
        end else begin
            m2_tick = (m2_div == 0);
            if (m2_tick) begin
                q2.push_back(expect_at(m2_col, m2_row, 16, 2, 4, 12, 2, 2, 1'b0));
                if (m2_col == 23) begin
                    m2_col = 0;
                    m2_row = (m2_row == 18) ? 0 : m2_row + 1;
                end else begin
                    m2_col++;
                end
            end
            m2_div = (m2_div == 1) ? 0 : 1;
        end
    end

    // ---------------- monitors (sample on the falling edge)
    bit line0_done = 0;
    int hs_low_row0 = 0, de_row0 = 0;
    always @(negedge clk) begin
        if (!rst) begin
            check("tick0", t0, m0_tick);
            if (t0) begin
                check("sb0_avail", q0.size() > 0, 1);
                if (q0.size() > 0) begin
                    e0 = q0.pop_front();
                    check("sb0", {col0, row0, de0, hs0, vs0, ft0}, e0);
                end
                if (!line0_done && row0 == 0) begin
                    if (!hs0) hs_low_row0++;
                    if (de0) de_row0++;
                end
            end
        end
    end

    int  f2_cnt = 0, n2_ticks = 0;
    bit  f2_seen = 0;
    always @(negedge clk) begin
        if (rst) begin
            f2_seen = 0;
        end else begin
            check("tick2", t2, m2_tick);
            if (t2) begin
                n2_ticks++;
                check("sb2_avail", q2.size() > 0, 1);
                if (q2.size() > 0) begin
                    e2 = q2.pop_front();
                    check("sb2", {col2, row2, de2, hs2, vs2, ft2}, e2);
                end
            end
            if (ft2) begin
                if (f2_seen) check("frame2_ticks", n2_ticks, 24 * 19);
                f2_seen = 1;
                n2_ticks = 0;
                f2_cnt++;
            end
        end
    end

    int  last_t1, line1_start, n1_lines = 0;
    bit  have_t1 = 0, have_line1 = 0;
    always @(negedge clk) begin
        if (rst) begin
            have_t1 = 0;
            have_line1 = 0;
        end else if (t1) begin
            if (have_t1) check("t1_period", cyc - last_t1, 2);
            last_t1 = cyc;
            have_t1 = 1;
            check("hs1_pol", hs1, (col1 >= 656 && col1 <= 751));
            check("vs1_pol", vs1, (row1 >= 490 && row1 <= 491));
            if (col1 == 0) begin
                if (have_line1) begin
                    check("line1_clocks", cyc - line1_start, 1600);
                    n1_lines++;
                end
                line1_start = cyc;
                have_line1 = 1;
            end
        end
    end

    // ---------------- directed sequences
    task automatic wait_tick0(input int col, input int row, input int budget, input string name);
        bit found;
        found = 0;
        for (int i = 0; i < budget && !found; i++) begin
            @(negedge clk);
            if (t0 && col0 == col[9:0] && row0 == row[9:0]) found = 1;
        end
        if (!found) fail_timeout(name);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tick"}, t0, 0);
        check({tag, "_hs"}, hs0, 1);
        check({tag, "_vs"}, vs0, 1);
        check({tag, "_de"}, de0, 0);
        check({tag, "_col"}, col0, 0);
        check({tag, "_row"}, row0, 0);
        check({tag, "_ft"}, ft0, 0);
        check({tag, "_hs1"}, hs1, 0);
`ifdef VGA_TESTPAT_EN
        check({tag, "_rgb"}, {r0, g0, b0}, 12'h000);
`endif
    endtask

    vec_t vecs[9];

    initial begin
        vecs[0] = '{128, 1'b1, 1'b1, 12'h00F};
        vecs[1] = '{639, 1'b1, 1'b1, 12'hFFF};
        vecs[2] = '{640, 1'b0, 1'b1, 12'h000};
        vecs[3] = '{655, 1'b0, 1'b1, 12'h000};
        vecs[4] = '{656, 1'b0, 1'b0, 12'h000};
        vecs[5] = '{700, 1'b0, 1'b0, 12'h000};
        vecs[6] = '{751, 1'b0, 1'b0, 12'h000};
        vecs[7] = '{752, 1'b0, 1'b1, 12'h000};
        vecs[8] = '{799, 1'b0, 1'b1, 12'h000};

        repeat (3) @(posedge clk);
        #2;
        check_reset_outputs("rst_hold");
        rst = 1'b0;

        // first pulse 3 clocks after release, then every 4
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("t0_phase", t0, (i % 4) == 3);
            if (i == 1) check("de_before_tick", de0, 0);
            if (i == 3) begin
                check("first_col", col0, 0);
                check("first_row", row0, 0);
                check("first_de", de0, 1);
                check("first_hs", hs0, 1);
                check("first_vs", vs0, 1);
`ifdef VGA_TESTPAT_EN
                check("first_rgb", {r0, g0, b0}, 12'h000);
`endif
            end
        end

        foreach (vecs[k]) begin
            wait_tick0(vecs[k].col, 0, 4000, "wait_vec");
            check("vec_de", de0, vecs[k].de);
            check("vec_hs", hs0, vecs[k].hs);
            check("vec_vs", vs0, 1);
`ifdef VGA_TESTPAT_EN
            check("vec_rgb", {r0, g0, b0}, vecs[k].rgb);
            check("vec_rgb_model", {r0, g0, b0}, rgb_exp(vecs[k].col, vecs[k].de));
`endif
        end

        wait_tick0(0, 1, 20, "wait_row1");
        check("row_inc", row0, 1);
        line0_done = 1;
        check("hs_low_ticks", hs_low_row0, 96);
        check("de_ticks", de_row0, 640);

        // abort mid-line; outputs must clear without waiting for a clock edge
        wait_tick0(300, 1, 1400, "wait_abort_point");
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check_reset_outputs("rst_async");
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        begin
            int k;
            k = 0;
            for (int i = 1; i <= 6 && k == 0; i++) begin
                @(posedge clk);
                @(negedge clk);
                if (t0) k = i;
            end
            check("restart_latency", k, 3);
            check("restart_col", col0, 0);
            check("restart_row", row0, 0);
        end

        repeat (40) @(posedge clk);
        @(negedge clk);
        check("dut1_lines_seen", n1_lines >= 2, 1);
        check("dut2_frames_seen", f2_cnt >= 2, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
